// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   state_t   - controller FSM encoding (RUN, STALL, FREEZE)
//   REG_W     - register-specifier width
//   ZERO_REG  - architectural $zero specifier (never a real dependency)
//   is_load_use() - load-use dependency detect between EX load and ID sources
// ---------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      FREEZE = 2'd2
   } state_t;

   localparam int                REG_W    = 5;
   localparam logic [REG_W-1:0]  ZERO_REG = 5'd0;

   // A load writing $zero produces nothing, so it can never cause a hazard.
   // rt only counts as a source when the ID instruction actually reads it.
   function automatic logic is_load_use(
      input logic             mem_read,
      input logic [REG_W-1:0] ex_rt,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             uses_rt
   );
      is_load_use = mem_read && (ex_rt != ZERO_REG) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for hazard statistics.
//   clock - rising-edge clock
//   reset - synchronous active-high clear (has priority over inc)
//   inc   - count this cycle
//   count - current value; holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
   localparam logic [W-1:0] ONE      = W'(1);

   // Count register: clear on reset, otherwise increment until saturated.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= {W{1'b0}};
      end else if (inc && (count != ALL_ONES)) begin
         count <= count + ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the 5-stage MIPS32 pipeline. Control outputs are a
// combinational function of the current state and inputs, so a hazard is
// acted on in the same cycle it is presented.
//   clock, reset          - clock and synchronous active-high reset
//   id_ex_mem_read/id_ex_rt - load in EX and its destination register
//   if_id_rs/if_id_rt/if_id_uses_rt - source operands of the ID instruction
//   branch_taken          - branch resolved taken in EX
//   jump                  - jump decoded in ID
//   mem_busy              - memory not ready; freeze the whole front end
//   pc_write, if_id_write, if_id_flush, id_ex_bubble - pipeline controls
//   stall_count, flush_count - saturating statistics
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // Remaining stall cycles loaded when a multi-cycle load-use stall begins.
   localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

   state_t     state_r;
   state_t     resume_state_r;
   logic [3:0] stall_cnt_r;

   state_t     next_state_s;
   state_t     next_resume_s;
   logic [3:0] next_cnt_s;
   state_t     eval_state_s;
   logic       load_use_s;
   logic       stall_inc_s;

   assign load_use_s = is_load_use(id_ex_mem_read, id_ex_rt, if_id_rs,
                                   if_id_rt, if_id_uses_rt);

   // Output decode and next-state selection for the current cycle.
   always_comb begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      next_state_s  = state_r;
      next_resume_s = resume_state_r;
      next_cnt_s    = stall_cnt_r;
      // Leaving FREEZE behaves exactly like the interrupted state.
      eval_state_s  = (state_r == FREEZE) ? resume_state_r : state_r;

      if (reset) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         next_state_s = RUN;
      end else if (mem_busy) begin
         // All controls low; remember where to resume unless already frozen.
         if (state_r != FREEZE) begin
            next_resume_s = state_r;
         end else begin
            next_resume_s = resume_state_r;
         end
         next_state_s = FREEZE;
      end else begin
         case (eval_state_s)
            RUN: begin
               if (branch_taken) begin
                  // ID holds a wrong-path instruction: squash it regardless.
                  pc_write     = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  next_state_s = RUN;
               end else if (load_use_s) begin
                  id_ex_bubble = 1'b1;
                  if (LOAD_LAT == 1) begin
                     next_state_s = RUN;
                  end else begin
                     next_cnt_s   = LAT_M1;
                     next_state_s = STALL;
                  end
               end else if (jump) begin
                  pc_write     = 1'b1;
                  if_id_flush  = 1'b1;
                  next_state_s = RUN;
               end else begin
                  pc_write     = 1'b1;
                  if_id_write  = 1'b1;
                  next_state_s = RUN;
               end
            end
            STALL: begin
               if (branch_taken) begin
                  pc_write     = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  next_cnt_s   = 4'd0;
                  next_state_s = RUN;
               end else begin
                  id_ex_bubble = 1'b1;
                  next_cnt_s   = stall_cnt_r - 4'd1;
                  if (stall_cnt_r == 4'd1) begin
                     next_state_s = RUN;
                  end else begin
                     next_state_s = STALL;
                  end
               end
            end
            default: begin
               // Unreachable encoding: squash and recover to RUN.
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               next_cnt_s   = 4'd0;
               next_state_s = RUN;
            end
         endcase
      end
   end

   // FSM state, resume target and stall countdown registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= RUN;
         resume_state_r <= RUN;
         stall_cnt_r    <= 4'd0;
      end else begin
         state_r        <= next_state_s;
         resume_state_r <= next_resume_s;
         stall_cnt_r    <= next_cnt_s;
      end
   end

   assign stall_inc_s = ~pc_write;

   sat_counter #(.W(CNT_W)) u_stall_stat (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc_s),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_stat (
      .clock (clock),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share the stimulus: one with
// a single-cycle load latency and one with a three-cycle latency. Control
// outputs are packed {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rt;
   logic [4:0]  if_id_rs;
   logic [4:0]  if_id_rt;
   logic        if_id_uses_rt;
   logic        branch_taken;
   logic        jump;
   logic        mem_busy;

   logic        pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1;
   logic        pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3;
   logic [15:0] stall_count1, flush_count1, stall_count3, flush_count3;
   logic [3:0]  ctl1, ctl3;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] CTL_RESET  = 4'b0011;
   localparam logic [3:0] CTL_NORMAL = 4'b1100;
   localparam logic [3:0] CTL_STALL  = 4'b0001;
   localparam logic [3:0] CTL_ZERO   = 4'b0000;
   localparam logic [3:0] CTL_BRANCH = 4'b1011;
   localparam logic [3:0] CTL_JUMP   = 4'b1010;

   assign ctl1 = {pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1};
   assign ctl3 = {pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3};

   always #5 clock = ~clock;

   hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
      .clock(clock), .reset(reset),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
      .pc_write(pc_write1), .if_id_write(if_id_write1),
      .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
      .stall_count(stall_count1), .flush_count(flush_count1)
   );

   hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
      .clock(clock), .reset(reset),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
      .pc_write(pc_write3), .if_id_write(if_id_write3),
      .if_id_flush(if_id_flush3), .id_ex_bubble(id_ex_bubble3),
      .stall_count(stall_count3), .flush_count(flush_count3)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_ex_mem_read = 1'b0;
      id_ex_rt       = 5'd0;
      if_id_rs       = 5'd0;
      if_id_rt       = 5'd0;
      if_id_uses_rt  = 1'b0;
      branch_taken   = 1'b0;
      jump           = 1'b0;
      mem_busy       = 1'b0;
   endtask

   task automatic load_use_8();
      id_ex_mem_read = 1'b1;
      id_ex_rt       = 5'd8;
      if_id_rs       = 5'd8;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      @(negedge clock);
      check_eq("reset_ctl1", 32'(ctl1), 32'(CTL_RESET));
      check_eq("reset_ctl3", 32'(ctl3), 32'(CTL_RESET));
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();

      // Single-cycle load-use stall.
      do_reset();
      check_eq("post_reset_stall_cnt", 32'(stall_count1), 32'd0);
      load_use_8();
      @(negedge clock);
      check_eq("lu1_stall", 32'(ctl1), 32'(CTL_STALL));
      tick(); idle();
      @(negedge clock);
      check_eq("lu1_resume", 32'(ctl1), 32'(CTL_NORMAL));
      check_eq("lu1_stall_count", 32'(stall_count1), 32'd1);

      // Non-hazards: load to $zero, and rt match when rt is not a source.
      tick();
      id_ex_mem_read = 1'b1;
      @(negedge clock);
      check_eq("zero_reg_no_stall", 32'(ctl1), 32'(CTL_NORMAL));
      tick();
      id_ex_rt = 5'd9; if_id_rt = 5'd9; if_id_rs = 5'd3;
      @(negedge clock);
      check_eq("rt_unused_no_stall", 32'(ctl1), 32'(CTL_NORMAL));
      tick();
      if_id_uses_rt = 1'b1;
      @(negedge clock);
      check_eq("rt_used_stall", 32'(ctl1), 32'(CTL_STALL));

      // Three-cycle stall runs to completion.
      do_reset();
      load_use_8();
      @(negedge clock);
      check_eq("lu3_c1", 32'(ctl3), 32'(CTL_STALL));
      tick(); idle();
      @(negedge clock);
      check_eq("lu3_c2", 32'(ctl3), 32'(CTL_STALL));
      tick();
      @(negedge clock);
      check_eq("lu3_c3", 32'(ctl3), 32'(CTL_STALL));
      tick();
      @(negedge clock);
      check_eq("lu3_run", 32'(ctl3), 32'(CTL_NORMAL));
      check_eq("lu3_stall_count", 32'(stall_count3), 32'd3);

      // Taken branch in the second stall cycle aborts the stall.
      do_reset();
      load_use_8();
      tick(); idle();
      branch_taken = 1'b1;
      @(negedge clock);
      check_eq("abort_branch", 32'(ctl3), 32'(CTL_BRANCH));
      tick(); idle();
      @(negedge clock);
      check_eq("abort_run", 32'(ctl3), 32'(CTL_NORMAL));
      check_eq("abort_stall_count", 32'(stall_count3), 32'd1);
      check_eq("abort_flush_count", 32'(flush_count3), 32'd1);

      // Freeze for four cycles at stall_cnt=2, then two remaining stalls.
      do_reset();
      load_use_8();
      tick(); idle();
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq($sformatf("freeze_c%0d", i), 32'(ctl3), 32'(CTL_ZERO));
         tick();
      end
      mem_busy = 1'b0;
      @(negedge clock);
      check_eq("unfreeze_s1", 32'(ctl3), 32'(CTL_STALL));
      tick();
      @(negedge clock);
      check_eq("unfreeze_s2", 32'(ctl3), 32'(CTL_STALL));
      tick();
      @(negedge clock);
      check_eq("unfreeze_run", 32'(ctl3), 32'(CTL_NORMAL));
      check_eq("unfreeze_stall_count", 32'(stall_count3), 32'd7);

      // Branch, jump and load-use together: branch wins.
      do_reset();
      load_use_8();
      branch_taken = 1'b1;
      jump         = 1'b1;
      @(negedge clock);
      check_eq("all3_ctl", 32'(ctl1), 32'(CTL_BRANCH));
      tick(); idle();
      jump = 1'b1;
      @(negedge clock);
      check_eq("all3_flush_count", 32'(flush_count1), 32'd1);
      check_eq("jump_only", 32'(ctl1), 32'(CTL_JUMP));

      // Reset asserted while frozen.
      do_reset();
      mem_busy = 1'b1;
      tick(); tick();
      check_eq("pre_reset_stall_count", 32'(stall_count1), 32'd2);
      reset = 1'b1;
      @(negedge clock);
      check_eq("reset_in_freeze", 32'(ctl1), 32'(CTL_RESET));
      tick();
      reset = 1'b0;
      idle();
      @(negedge clock);
      check_eq("after_reset_run", 32'(ctl1), 32'(CTL_NORMAL));
      check_eq("after_reset_stall_count", 32'(stall_count1), 32'd0);
      check_eq("after_reset_flush_count", 32'(flush_count1), 32'd0);

      // Saturation of the stall statistic under a long freeze.
      do_reset();
      mem_busy = 1'b1;
      repeat (65534) tick();
      check_eq("sat_fffe", 32'(stall_count1), 32'h0000_FFFE);
      tick();
      check_eq("sat_ffff", 32'(stall_count1), 32'h0000_FFFF);
      repeat (4465) tick();
      check_eq("sat_hold1", 32'(stall_count1), 32'h0000_FFFF);
      check_eq("sat_hold3", 32'(stall_count3), 32'h0000_FFFF);
      check_eq("sat_flush_zero", 32'(flush_count1), 32'd0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
